// File: rtl/mastermind_solver.sv
// Mastermind codebreaker: issues the lowest 4-peg code consistent with every
// scored guess so far, one (candidate, history entry) check per cycle.
module mastermind_solver #(
  parameter int unsigned MAX_GUESSES = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic [11:0] guess_out,
  output logic        guess_valid,
  input  logic        guess_ready,
  input  logic        fb_valid,
  input  logic [2:0]  red_in,
  input  logic [2:0]  white_in,
  output logic        busy,
  output logic        solved,
  output logic        failed,
  output logic        err,
  output logic [3:0]  guess_count
);

  localparam int unsigned CODE_W     = 12;
  localparam int unsigned PEG_W      = 3;
  localparam int unsigned HIST_DEPTH = 8;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEARCH,
    S_PRESENT,
    S_WAIT_FB,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [CODE_W-1:0] guess;
    logic [PEG_W-1:0]  red;
    logic [PEG_W-1:0]  white;
  } hist_t;

  state_e            state_q, state_d;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  hist_cnt_q, hist_cnt_d;
  hist_t             hist_q [HIST_DEPTH];
  hist_t             hist_d [HIST_DEPTH];
  logic [CODE_W-1:0] guess_out_q, guess_out_d;
  logic              guess_valid_q, guess_valid_d;
  logic              busy_q, busy_d;
  logic              solved_q, solved_d;
  logic              failed_q, failed_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [PEG_W-1:0]  s_red_c, s_white_c;
  logic              cand_match_c;
  logic [CNT_W-1:0]  fb_sum_c;

  // Red = same colour same slot; white = colour overlap over all slots minus red.
  function automatic logic [5:0] score(input logic [CODE_W-1:0] a, input logic [CODE_W-1:0] b);
    logic [PEG_W-1:0] red, common, ca, cb;
    red    = '0;
    common = '0;
    for (int i = 0; i < 4; i++) begin
      if (a[3*i +: 3] == b[3*i +: 3]) red = red + 3'd1;
    end
    for (int k = 0; k < 8; k++) begin
      ca = '0;
      cb = '0;
      for (int i = 0; i < 4; i++) begin
        if (a[3*i +: 3] == 3'(k)) ca = ca + 3'd1;
        if (b[3*i +: 3] == 3'(k)) cb = cb + 3'd1;
      end
      common = common + ((ca < cb) ? ca : cb);
    end
    return {red, 3'(common - red)};
  endfunction

  assign {s_red_c, s_white_c} = score(cand_q, hist_q[idx_q].guess);
  assign cand_match_c = (s_red_c == hist_q[idx_q].red) && (s_white_c == hist_q[idx_q].white);
  assign fb_sum_c     = CNT_W'(red_in) + CNT_W'(white_in);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      cand_q        <= '0;
      idx_q         <= '0;
      hist_cnt_q    <= '0;
      hist_q        <= '{default: '0};
      guess_out_q   <= '0;
      guess_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      solved_q      <= 1'b0;
      failed_q      <= 1'b0;
      err_q         <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      cand_q        <= cand_d;
      idx_q         <= idx_d;
      hist_cnt_q    <= hist_cnt_d;
      hist_q        <= hist_d;
      guess_out_q   <= guess_out_d;
      guess_valid_q <= guess_valid_d;
      busy_q        <= busy_d;
      solved_q      <= solved_d;
      failed_q      <= failed_d;
      err_q         <= err_d;
      count_q       <= count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cand_d        = cand_q;
    idx_d         = idx_q;
    hist_cnt_d    = hist_cnt_q;
    hist_d        = hist_q;
    guess_out_d   = guess_out_q;
    guess_valid_d = guess_valid_q;
    solved_d      = solved_q;
    failed_d      = failed_q;
    err_d         = err_q;
    count_d       = count_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_SEARCH;
          cand_d     = '0;
          idx_d      = '0;
          hist_cnt_d = '0;
          count_d    = '0;
          solved_d   = 1'b0;
          failed_d   = 1'b0;
          err_d      = 1'b0;
        end
      end
      S_SEARCH: begin
        if (hist_cnt_q == '0) begin
          state_d       = S_PRESENT;
          guess_out_d   = cand_q;
          guess_valid_d = 1'b1;
        end else if (!cand_match_c) begin
          // Exhausting the code space means the feedback contradicted itself.
          if (cand_q == {CODE_W{1'b1}}) begin
            state_d  = S_DONE;
            err_d    = 1'b1;
            failed_d = 1'b1;
          end else begin
            cand_d = cand_q + 12'd1;
            idx_d  = '0;
          end
        end else if (idx_q == IDX_W'(hist_cnt_q - 4'd1)) begin
          state_d       = S_PRESENT;
          guess_out_d   = cand_q;
          guess_valid_d = 1'b1;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_PRESENT: begin
        if (guess_ready) begin
          state_d       = S_WAIT_FB;
          guess_valid_d = 1'b0;
          count_d       = count_q + 4'd1;
        end
      end
      S_WAIT_FB: begin
        if (fb_valid) begin
          if ((fb_sum_c > 4'd4) || ((red_in == 3'd4) && (white_in != 3'd0))) begin
            state_d  = S_DONE;
            err_d    = 1'b1;
            failed_d = 1'b1;
          end else if (red_in == 3'd4) begin
            state_d  = S_DONE;
            solved_d = 1'b1;
          end else begin
            hist_d[hist_cnt_q[IDX_W-1:0]] = '{guess: cand_q, red: red_in, white: white_in};
            hist_cnt_d = hist_cnt_q + 4'd1;
            if (count_q == CNT_W'(MAX_GUESSES)) begin
              state_d  = S_DONE;
              failed_d = 1'b1;
            end else if (cand_q == {CODE_W{1'b1}}) begin
              state_d  = S_DONE;
              err_d    = 1'b1;
              failed_d = 1'b1;
            end else begin
              state_d = S_SEARCH;
              cand_d  = cand_q + 12'd1;
              idx_d   = '0;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_SEARCH) || (state_d == S_PRESENT) || (state_d == S_WAIT_FB);
  end

  assign guess_out   = guess_out_q;
  assign guess_valid = guess_valid_q;
  assign busy        = busy_q;
  assign solved      = solved_q;
  assign failed      = failed_q;
  assign err         = err_q;
  assign guess_count = count_q;

endmodule

// File: tb/tb_mastermind_solver.sv
// Bench for mastermind_solver: a reference solver predicts each guess and the
// final flags; predictions are queued at stimulus time and popped at DUT output.
module tb_mastermind_solver;

  localparam int MAXG  = 8;
  localparam int LIMIT = 40000;

  logic        clk, resetn, start, guess_valid, guess_ready, fb_valid;
  logic        busy, solved, failed, err;
  logic [11:0] guess_out;
  logic [2:0]  red_in, white_in;
  logic [3:0]  guess_count;

  mastermind_solver #(.MAX_GUESSES(MAXG)) dut (
    .clk(clk), .resetn(resetn), .start(start), .guess_out(guess_out),
    .guess_valid(guess_valid), .guess_ready(guess_ready), .fb_valid(fb_valid),
    .red_in(red_in), .white_in(white_in), .busy(busy), .solved(solved),
    .failed(failed), .err(err), .guess_count(guess_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          is_end;
    logic [11:0] guess;
    bit          solved;
    bit          failed;
    bit          err;
    int          count;
  } exp_t;

  // mode: 0 score vs secret, 1 always r0w0, 2 first r0w1, 3 first r2w3
  typedef struct {
    logic [11:0] secret;
    int          mode;
    bit          chk;
    bit          solved;
    bit          failed;
    bit          err;
    int          count;
  } vec_t;

  exp_t        sb_q[$];
  logic [11:0] th_guess[MAXG];
  int          th_r[MAXG];
  int          th_w[MAXG];
  int          th_n;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Greedy pairing scorer: exact pegs first, then match leftovers one-for-one.
  task automatic tb_score(input logic [11:0] a, input logic [11:0] b, output int r, output int w);
    logic [2:0] pa[4], pb[4];
    bit ua[4], ub[4], hit;
    r = 0;
    w = 0;
    for (int i = 0; i < 4; i++) begin
      pa[i] = a[3*i +: 3];
      pb[i] = b[3*i +: 3];
      ua[i] = 0;
      ub[i] = 0;
    end
    for (int i = 0; i < 4; i++) if (pa[i] == pb[i]) begin r++; ua[i] = 1; ub[i] = 1; end
    for (int i = 0; i < 4; i++) begin
      hit = 0;
      for (int j = 0; j < 4; j++) begin
        if (!ua[i] && !ub[j] && !hit && pa[i] == pb[j]) begin w++; ub[j] = 1; hit = 1; end
      end
    end
  endtask

  task automatic model_next(input int from, output bit found, output logic [11:0] code);
    int r, w;
    bit ok;
    found = 0;
    code  = '0;
    for (int c = from; c < 4096 && !found; c++) begin
      ok = 1;
      for (int i = 0; i < th_n; i++) begin
        tb_score(12'(c), th_guess[i], r, w);
        if (r != th_r[i] || w != th_w[i]) ok = 0;
      end
      if (ok) begin found = 1; code = 12'(c); end
    end
  endtask

  task automatic run_game(input logic [11:0] secret, input int mode,
                          output bit o_solved, output bit o_failed, output bit o_err, output int o_count);
    exp_t        e;
    int          cyc, n, r, w;
    bit          over, ok, found;
    logic [11:0] g, nx;
    th_n = 0;
    sb_q.delete();
    o_solved = 0; o_failed = 0; o_err = 0; o_count = -1;
    e = '{is_end: 0, guess: '0, solved: 0, failed: 0, err: 0, count: 0};
    sb_q.push_back(e);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    over = 0;
    while (!over) begin
      cyc = 0;
      while (!guess_valid && busy && cyc < LIMIT) begin tick(); cyc++; end
      if (cyc >= LIMIT) begin
        bound_fail("game_wait");
        over = 1;
      end else if (sb_q.size() == 0 || n > MAXG) begin
        bound_fail("scoreboard_empty");
        over = 1;
      end else begin
        e = sb_q.pop_front();
        if (guess_valid) begin
          check("kind_guess", 32'(e.is_end), 32'd0);
          check("guess", 32'(guess_out), 32'(e.guess));
          ok = 1;
          for (int i = 0; i < th_n; i++) begin
            tb_score(guess_out, th_guess[i], r, w);
            if (r != th_r[i] || w != th_w[i]) ok = 0;
          end
          check("consistent", 32'(ok), 32'd1);
          g = guess_out;
          guess_ready = 1'b1;
          tick();
          guess_ready = 1'b0;
          n++;
          check("count_accept", 32'(guess_count), 32'(n));
          check("valid_drop", 32'(guess_valid), 32'd0);
          if (mode == 0) tb_score(g, secret, r, w);
          else if (mode == 2 && n == 1) begin r = 0; w = 1; end
          else if (mode == 3 && n == 1) begin r = 2; w = 3; end
          else begin r = 0; w = 0; end
          e = '{is_end: 1, guess: g, solved: 0, failed: 1, err: 0, count: n};
          if (r + w > 4 || (r == 4 && w != 0)) e.err = 1;
          else if (r == 4) begin e.solved = 1; e.failed = 0; end
          else begin
            th_guess[th_n] = g; th_r[th_n] = r; th_w[th_n] = w; th_n++;
            if (n == MAXG) e.failed = 1;
            else if (g == 12'hFFF) e.err = 1;
            else begin
              model_next(int'(g) + 1, found, nx);
              if (found) begin e.is_end = 0; e.guess = nx; e.failed = 0; end
              else e.err = 1;
            end
          end
          sb_q.push_back(e);
          fb_valid = 1'b1;
          red_in   = 3'(r);
          white_in = 3'(w);
          tick();
          fb_valid = 1'b0;
        end else begin
          check("kind_end", 32'(e.is_end), 32'd1);
          check("solved", 32'(solved), 32'(e.solved));
          check("failed", 32'(failed), 32'(e.failed));
          check("err", 32'(err), 32'(e.err));
          check("count_end", 32'(guess_count), 32'(e.count));
          o_solved = solved; o_failed = failed; o_err = err; o_count = int'(guess_count);
          over = 1;
        end
      end
    end
  endtask

  initial begin
    vec_t vecs[8];
    bit   s, f, e;
    int   cnt, cyc;

    vecs[0] = '{secret: 12'o0001, mode: 0, chk: 1, solved: 1, failed: 0, err: 0, count: 2};
    vecs[1] = '{secret: 12'o0000, mode: 1, chk: 1, solved: 0, failed: 1, err: 0, count: 8};
    vecs[2] = '{secret: 12'o0000, mode: 2, chk: 1, solved: 0, failed: 1, err: 1, count: 1};
    vecs[3] = '{secret: 12'o0000, mode: 3, chk: 1, solved: 0, failed: 1, err: 1, count: 1};
    vecs[4] = '{secret: 12'o0000, mode: 0, chk: 1, solved: 1, failed: 0, err: 0, count: 1};
    vecs[5] = '{secret: 12'o7654, mode: 0, chk: 0, solved: 0, failed: 0, err: 0, count: 0};
    vecs[6] = '{secret: 12'($urandom_range(0, 4095)), mode: 0, chk: 0, solved: 0, failed: 0, err: 0, count: 0};
    vecs[7] = '{secret: 12'($urandom_range(0, 4095)), mode: 0, chk: 0, solved: 0, failed: 0, err: 0, count: 0};

    resetn = 1'b0; start = 1'b0; guess_ready = 1'b0; fb_valid = 1'b0;
    red_in = '0; white_in = '0;
    #2;
    check("reset_outputs", 32'({guess_out, guess_valid, busy, solved, failed, err, guess_count}), 32'd0);
    #10 resetn = 1'b1;
    tick();

    // First-guess latency, stall in PRESENT, and ignored start/fb_valid.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("lat1_valid", 32'(guess_valid), 32'd0);
    check("lat1_busy", 32'(busy), 32'd1);
    tick();
    check("lat2_valid", 32'(guess_valid), 32'd1);
    check("lat2_guess", 32'(guess_out), 32'd0);
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      start = 1'b0;
      check("stall_guess", 32'({guess_valid, guess_out}), 32'({1'b1, 12'o0000}));
    end
    check("stall_count", 32'(guess_count), 32'd0);
    guess_ready = 1'b1;
    tick();
    guess_ready = 1'b0;
    check("accept_count", 32'(guess_count), 32'd1);
    check("accept_busy", 32'(busy), 32'd1);
    fb_valid = 1'b1; red_in = 3'd3; white_in = 3'd0;
    tick();
    red_in = 3'd4; start = 1'b1;
    tick();
    fb_valid = 1'b0; start = 1'b0;
    check("ignored_fb_solved", 32'(solved), 32'd0);
    check("second_guess", 32'({guess_valid, guess_out}), 32'({1'b1, 12'o0001}));
    check("second_count", 32'(guess_count), 32'd1);
    guess_ready = 1'b1;
    tick();
    guess_ready = 1'b0;
    fb_valid = 1'b1; red_in = 3'd4; white_in = 3'd0;
    tick();
    fb_valid = 1'b0;
    check("solve_flags", 32'({solved, failed, err, busy}), 32'b1000);
    check("solve_count", 32'(guess_count), 32'd2);
    check("done_holds_guess", 32'(guess_out), 32'(12'o0001));

    for (int v = 0; v < 8; v++) begin
      run_game(vecs[v].secret, vecs[v].mode, s, f, e, cnt);
      if (vecs[v].chk) begin
        check("tbl_solved", 32'(s), 32'(vecs[v].solved));
        check("tbl_failed", 32'(f), 32'(vecs[v].failed));
        check("tbl_err", 32'(e), 32'(vecs[v].err));
        check("tbl_count", 32'(cnt), 32'(vecs[v].count));
      end
    end

    // Asynchronous reset while the search is running.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    guess_ready = 1'b1;
    tick();
    guess_ready = 1'b0;
    fb_valid = 1'b1; red_in = 3'd0; white_in = 3'd0;
    tick();
    fb_valid = 1'b0;
    cyc = 0;
    while (!guess_valid && cyc < LIMIT) begin tick(); cyc++; end
    if (cyc >= LIMIT) bound_fail("rst_seq_wait");
    check("rst_seq_guess", 32'(guess_out), 32'(12'o1111));
    guess_ready = 1'b1;
    tick();
    guess_ready = 1'b0;
    fb_valid = 1'b1;
    tick();
    fb_valid = 1'b0;
    repeat (5) tick();
    check("rst_seq_busy", 32'({busy, guess_count}), 32'({1'b1, 4'd2}));
    resetn = 1'b0;
    #1;
    check("midgame_reset", 32'({guess_out, guess_valid, busy, solved, failed, err, guess_count}), 32'd0);
    #2 resetn = 1'b1;
    tick();
    check("post_reset_idle", 32'({busy, guess_valid}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
